mem_wait_ctrl: RTL
==================

Name: mem_wait_ctrl

Overview:
Memory-side responder for the multicycle RV32 core's phase sequencer. It accepts one access request per instruction phase (fetch or memory-access), drives a synchronous req/ack memory port, and enforces a programmable minimum number of wait states. It holds memWait high until the access completes, so the phase clock generator stalls its phase counter. It also returns read data and flags a timeout error if the memory never acknowledges.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte-enable width = DATA_W/8)
WAIT_CYCLES, 2, minimum wait cycles between issue and completion (0..15)
TIMEOUT, 255, maximum WAIT-state cycles before forced completion with error (>= WAIT_CYCLES+1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
req  in  1  one-cycle access strobe from sequencer
rwmem  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  byte address; sampled with req
wdata  in  DATA_W  write data; sampled with req
be  in  DATA_W/8  byte enables; sampled with req
memWait  out  1  high while access pending; sequencer must not advance
rdata  out  DATA_W  last completed read data
err  out  1  last access timed out
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_ack  in  1  memory acknowledge (read data valid when we=0)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, RST_N=0): state=IDLE; memWait (registered part)=0, rdata=0, err=0, mem_req=0, mem_we=0, mem_addr/mem_wdata/mem_be=0; wait and timeout counters=0; ack_seen=0. Reset mid-access aborts it at once; mem_req drops asynchronously.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: when req=1, capture rwmem/addr/wdata/be into holding regs, clear err, go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): mem_req=1; mem_we/addr/wdata/be driven from holding regs; load wcnt=WAIT_CYCLES, tcnt=0, ack_seen=0; go to WAIT.
- WAIT: mem_req remains 1. If wcnt!=0, decrement it. mem_ack=1 sets ack_seen. Exit to DONE when wcnt==0 and (mem_ack or ack_seen). On a read exit, rdata <= mem_rdata if mem_ack is high that cycle, else the value captured when ack_seen was set. tcnt increments each WAIT cycle. If tcnt==TIMEOUT-1 without a normal exit, go to DONE with err=1; a read then leaves rdata=0.
- DONE (1 cycle): mem_req=0, memWait=0. If req=1, accept it as in IDLE and go directly to ISSUE; otherwise go to IDLE.
- memWait = (req & (IDLE|DONE)) | ISSUE | WAIT. The req term is combinational, so the sequencer sees the stall in the same cycle as the request.
- req while in ISSUE or WAIT is ignored. No queuing.
- Minimum memWait duration = 3 + WAIT_CYCLES cycles (req cycle, ISSUE, WAIT_CYCLES+1 WAIT cycles).
- Writes never modify rdata. rdata holds until the next read completes. err holds until the next accepted req.
- The mem_* outputs are registered. mem_addr/mem_wdata/mem_be/mem_we hold their values after completion.
- mem_ack outside WAIT is ignored.

Test Plan:
- Reset: assert RST_N=0 mid-WAIT -> mem_req=0 and memWait=0 immediately; all outputs 0; state IDLE after release.
- Read, WAIT_CYCLES=2, mem_ack tied high, mem_rdata=32'hDEADBEEF: req at cycle 0 -> memWait high for cycles 0–4, mem_req high cycles 1–4, DONE at cycle 5, rdata=32'hDEADBEEF, err=0.
- Early ack, WAIT_CYCLES=2: single-cycle mem_ack (rdata=32'h12345678) in the first WAIT cycle -> ack_seen held, exit still in cycle 4, rdata=32'h12345678.
- Write addr=32'h100, wdata=32'hA5A5A5A5, be=4'b0011 -> mem_we=1, mem_be=4'b0011 for ISSUE/WAIT; rdata unchanged from the previous read.
- Timeout, TIMEOUT=8, mem_ack=0 -> DONE after 8 WAIT cycles, err=1, rdata=0. The next req clears err.
- Back-to-back: req asserted in DONE cycle -> goes directly to ISSUE, memWait stays high without a gap; req during WAIT ignored (exactly one mem_req burst).

Source files
------------

// File: rtl/mem_wait_ctrl.sv
// Memory-side responder for the multicycle core's phase sequencer.
// Takes one request per fetch or memory phase and drives a req/ack memory port.
// It enforces a minimum number of wait states before an access can complete.
// memWait stays high until the access completes, which stalls the phase counter.
// If memory never acknowledges, the access is forced to complete with err set.

module mem_wait_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                CLK,
    input  logic                RST_N,

    // Sequencer side
    input  logic                req,
    input  logic                rwmem,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                memWait,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,

    // Memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BeW    = DATA_W / 8;
    localparam int unsigned TcntW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);
    localparam logic [3:0]       WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e             state_q;
    logic [3:0]         wcnt_q;
    logic [TcntW-1:0]   tcnt_q;
    logic               ack_seen_q;
    logic [DATA_W-1:0]  ack_data_q;
    logic               busy_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    // The mem_* registers double as the request holding registers: they are loaded
    // when the request is accepted and keep their values after completion.
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [BeW-1:0]     mem_be_q;

    logic               accept;
    logic               exit_ok;
    logic               exit_timeout;

    // Decode request acceptance, WAIT exit conditions and the combined stall output
    always_comb begin
        accept       = req & ((state_q == StIdle) | (state_q == StDone));
        exit_ok      = (state_q == StWait) & (wcnt_q == 4'd0) & (mem_ack | ack_seen_q);
        // A normal exit takes priority over a timeout in the same cycle
        exit_timeout = (state_q == StWait) & ~exit_ok & (tcnt_q == TcntLast);
        // busy_q covers ISSUE and WAIT; the req term stalls the sequencer in the request cycle
        memWait      = busy_q | accept;
    end

    // Access sequencer with registered memory-port and result outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            wcnt_q      <= 4'd0;
            tcnt_q      <= '0;
            ack_seen_q  <= 1'b0;
            ack_data_q  <= '0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        mem_we_q    <= rwmem;
                        mem_addr_q  <= addr;
                        mem_wdata_q <= wdata;
                        mem_be_q    <= be;
                        // mem_req rises together with ISSUE so the port sees it that cycle
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        state_q     <= StIssue;
                    end else begin
                        state_q     <= StIdle;
                    end
                end

                StIssue: begin
                    wcnt_q     <= WaitLoad;
                    tcnt_q     <= '0;
                    ack_seen_q <= 1'b0;
                    state_q    <= StWait;
                end

                StWait: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                    tcnt_q <= tcnt_q + TcntW'(1);
                    // Keep the data from the first acknowledge in case the ack is not held
                    if (mem_ack && !ack_seen_q) begin
                        ack_seen_q <= 1'b1;
                        ack_data_q <= mem_rdata;
                    end

                    if (exit_ok) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_ack ? mem_rdata : ack_data_q;
                        end
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= StDone;
                    end else if (exit_timeout) begin
                        if (!mem_we_q) begin
                            rdata_q <= '0;
                        end
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= StDone;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
